udp_pkt_rx_parser: RTL and testbench

//  Inline tap on the 64-bit user datapath that receives UDP/IPv4 packets and checks them.

---
 rtl/udp_pkt_rx_parser_pkg.sv | 33 +++
 rtl/ip_chksum_acc.sv | 43 ++++
 rtl/udp_pkt_rx_parser.sv | 207 ++++++++++++++++++++
 tb/tb_udp_pkt_rx_parser.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkt_rx_parser_pkg.sv
// Shared types and constants for the UDP/IPv4 receive parser.
// Holds the one-hot FSM state encoding, packet verdicts and header field constants.
package udp_pkt_rx_parser_pkg;

  typedef enum logic [6:0] {
    ST_MOD_HDR = 7'b000_0001,
    ST_HDR2    = 7'b000_0010,
    ST_HDR3    = 7'b000_0100,
    ST_HDR4    = 7'b000_1000,
    ST_HDR5    = 7'b001_0000,
    ST_PAYLOAD = 7'b010_0000,
    ST_SKIP    = 7'b100_0000
  } state_t;

  typedef enum logic [1:0] {
    V_NONE,
    V_MATCH,
    V_CHK_ERR,
    V_OTHER
  } verdict_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

  // Header mismatch dominates; a bad checksum only matters for otherwise matching packets.
  function automatic verdict_t classify(input logic fail, input logic chk_good);
    if (fail)          return V_OTHER;
    else if (!chk_good) return V_CHK_ERR;
    else               return V_MATCH;
  endfunction

endpackage

// File: rtl/ip_chksum_acc.sv
// 17-bit one's-complement accumulator for the IPv4 header checksum.
// Present only when UDP_RX_CHKSUM_EN is defined; good reflects the sum including the current addends.
`ifdef UDP_RX_CHKSUM_EN
module ip_chksum_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        add_en,
  input  logic [15:0] add0,
  input  logic [15:0] add1,
  input  logic [15:0] add2,
  input  logic [15:0] add3,
  input  logic [3:0]  add_mask,
  output logic        good
);

  logic [16:0] acc;
  logic [16:0] acc_next;
  logic [16:0] fold;
  logic [18:0] sum;

  // Fold the held carry in before adding, then fold the new carries back to 17 bits.
  always_comb begin
    sum = 19'(acc[15:0]) + 19'(acc[16])
        + (add_mask[0] ? 19'(add0) : 19'd0)
        + (add_mask[1] ? 19'(add1) : 19'd0)
        + (add_mask[2] ? 19'(add2) : 19'd0)
        + (add_mask[3] ? 19'(add3) : 19'd0);
    acc_next = 17'(sum[15:0]) + 17'(sum[18:16]);
    fold     = 17'(acc_next[15:0]) + 17'(acc_next[16]);
    good     = (fold == 17'h0FFFF);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc_next;
    end
  end

endmodule
`endif

// File: rtl/udp_pkt_rx_parser.sv
// Inline UDP/IPv4 receive tap: 1-cycle pass-through, header classification, payload extraction, stats.
// Build option UDP_RX_CHKSUM_EN enables IPv4 header checksum verification and chksum_err_cnt.
module udp_pkt_rx_parser
  import udp_pkt_rx_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  enable,
  input  logic [31:0]           match_ip_dst,
  input  logic [15:0]           match_udp_port,
  output logic [DATA_WIDTH-1:0] pld_data,
  output logic                  pld_valid,
  output logic                  pld_last,
  output logic                  pkt_match,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  chksum_err_cnt,
  output logic [CNT_WIDTH-1:0]  other_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t   state, state_next;
  verdict_t verdict_q, verdict_now, cnt_sel;
  logic     eop, w1_accept, hdr_ok, fail_q, chk_good, pld_fire;
  logic [31:0] ip_q;
  logic [15:0] port_q, dst_hi_q;

  assign in_rdy    = out_rdy;
  assign eop       = (in_ctrl != '0);
  assign w1_accept = in_wr && (state == ST_MOD_HDR) && !eop;
  assign pld_fire  = in_wr && (state == ST_PAYLOAD) && (verdict_q == V_MATCH);

`ifdef UDP_RX_CHKSUM_EN
  logic [15:0] ck_a0, ck_a1, ck_a2, ck_a3;
  logic [3:0]  ck_mask;
  logic        ck_add_en;

  // W2 contributes ver/ihl+tos, W3/W4 all four halfwords, W5 only dst_ip_lo.
  always_comb begin
    ck_a0     = in_data[63:48];
    ck_a1     = in_data[47:32];
    ck_a2     = in_data[31:16];
    ck_a3     = in_data[15:0];
    ck_mask   = '0;
    ck_add_en = 1'b0;
    case (state)
      ST_HDR2: begin
        ck_a0     = in_data[15:0];
        ck_mask   = 4'b0001;
        ck_add_en = in_wr;
      end
      ST_HDR3, ST_HDR4: begin
        ck_mask   = 4'b1111;
        ck_add_en = in_wr;
      end
      ST_HDR5: begin
        ck_mask   = 4'b0001;
        ck_add_en = in_wr;
      end
      default: ;
    endcase
  end

  ip_chksum_acc u_chksum (
    .clk      (clk),
    .reset    (reset),
    .clr      (w1_accept),
    .add_en   (ck_add_en),
    .add0     (ck_a0),
    .add1     (ck_a1),
    .add2     (ck_a2),
    .add3     (ck_a3),
    .add_mask (ck_mask),
    .good     (chk_good)
  );
`else
  assign chk_good = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_MOD_HDR;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    hdr_ok      = 1'b1;
    verdict_now = V_OTHER;
    cnt_sel     = V_NONE;
    if (in_wr) begin
      case (state)
        ST_MOD_HDR: begin
          if (!eop) state_next = enable ? ST_HDR2 : ST_SKIP;
        end
        ST_HDR2: begin
          hdr_ok = (in_data[31:16] == ETHERTYPE_IPV4) && (in_data[15:8] == IP_VER_IHL);
          if (eop) begin cnt_sel = V_OTHER; state_next = ST_MOD_HDR; end
          else           state_next = ST_HDR3;
        end
        ST_HDR3: begin
          hdr_ok = (in_data[7:0] == IP_PROTO_UDP);
          if (eop) begin cnt_sel = V_OTHER; state_next = ST_MOD_HDR; end
          else           state_next = ST_HDR4;
        end
        ST_HDR4: begin
          if (eop) begin cnt_sel = V_OTHER; state_next = ST_MOD_HDR; end
          else           state_next = ST_HDR5;
        end
        ST_HDR5: begin
          hdr_ok = ({dst_hi_q, in_data[63:48]} == ip_q) && (in_data[31:16] == port_q);
          verdict_now = classify(fail_q || !hdr_ok, chk_good);
          if (eop) begin
            cnt_sel    = verdict_now;
            state_next = ST_MOD_HDR;
          end else begin
            state_next = (verdict_now == V_OTHER) ? ST_SKIP : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD, ST_SKIP: begin
          // Disabled packets carry V_NONE through SKIP, so they never count.
          if (eop) begin
            cnt_sel    = verdict_q;
            state_next = ST_MOD_HDR;
          end
        end
        default: state_next = ST_MOD_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      verdict_q <= V_NONE;
      fail_q    <= 1'b0;
      ip_q      <= '0;
      port_q    <= '0;
      dst_hi_q  <= '0;
    end else if (in_wr) begin
      case (state)
        ST_MOD_HDR: begin
          if (!eop) begin
            verdict_q <= V_NONE;
            fail_q    <= 1'b0;
            ip_q      <= match_ip_dst;
            port_q    <= match_udp_port;
          end
        end
        ST_HDR2, ST_HDR3: fail_q    <= fail_q | ~hdr_ok;
        ST_HDR4:          dst_hi_q  <= in_data[15:0];
        ST_HDR5:          verdict_q <= verdict_now;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_ctrl  <= '0;
      out_wr    <= 1'b0;
      pld_data  <= '0;
      pld_valid <= 1'b0;
      pld_last  <= 1'b0;
    end else begin
      out_data  <= in_data;
      out_ctrl  <= in_ctrl;
      out_wr    <= in_wr;
      pld_valid <= pld_fire;
      pld_last  <= pld_fire && eop;
      if (pld_fire) pld_data <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_match <= 1'b0;
      match_cnt <= '0;
      other_cnt <= '0;
    end else begin
      pkt_match <= (cnt_sel == V_MATCH);
      if (cnt_sel == V_MATCH) match_cnt <= match_cnt + CNT_ONE;
      if (cnt_sel == V_OTHER) other_cnt <= other_cnt + CNT_ONE;
    end
  end

`ifdef UDP_RX_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                      chksum_err_cnt <= '0;
    else if (cnt_sel == V_CHK_ERR)  chksum_err_cnt <= chksum_err_cnt + CNT_ONE;
  end
`else
  assign chksum_err_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_pkt_rx_parser.sv
// Directed testbench for udp_pkt_rx_parser; expectations follow UDP_RX_CHKSUM_EN when defined.
// Reference header checksum 16'h145B is hand-computed for the fixed header fields used below.
module tb_udp_pkt_rx_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] match_ip_dst = 32'h0A00_0002;
  logic [15:0] match_udp_port = 16'd5000;
  logic [63:0] pld_data;
  logic        pld_valid, pld_last, pkt_match;
  logic [31:0] match_cnt, chksum_err_cnt, other_cnt;

  int tests = 0;
  int fails = 0;
  int exp_match = 0, exp_chk = 0, exp_other = 0;

  always #5 clk = ~clk;

  udp_pkt_rx_parser #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .enable(enable), .match_ip_dst(match_ip_dst), .match_udp_port(match_udp_port),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_last(pld_last), .pkt_match(pkt_match),
    .match_cnt(match_cnt), .chksum_err_cnt(chksum_err_cnt), .other_cnt(other_cnt)
  );

  // Observation log (records only; tests compare against it).
  logic [63:0] q_pld[$];
  bit          q_last[$];
  int          dp_err = 0, match_pulses = 0, rdy_low = 0;
  bit          mon_on = 1'b0;
  logic [63:0] p_d = '0;
  logic [7:0]  p_c = '0;
  logic        p_w = 1'b0;

  always @(negedge clk) begin
    if (mon_on && (out_data !== p_d || out_ctrl !== p_c || out_wr !== p_w)) dp_err++;
    p_d = reset ? 64'd0 : in_data;
    p_c = reset ? 8'd0  : in_ctrl;
    p_w = reset ? 1'b0  : in_wr;
    if (pld_valid === 1'b1) begin
      q_pld.push_back(pld_data);
      q_last.push_back(pld_last);
    end
    if (pkt_match === 1'b1) match_pulses++;
  end

  function automatic logic [63:0] pld_word(input int seq, input int i);
    return {32'hDA7A_0000 + 32'(seq), 32'h5A5A_0000 ^ 32'(i)};
  endfunction

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    in_data = d; in_ctrl = c; in_wr = 1'b1;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    in_wr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // eop_word: header word carrying EOP (0 = none); stall_at / rst_at: payload index, -1 = none.
  task automatic send_pkt(input logic [15:0] etype, input logic [7:0] proto, input logic [15:0] dport,
                          input logic [15:0] chk_xor, input int npld, input int eop_word,
                          input int stall_at, input bit en_w3, input int rst_at, input int seq);
    logic [63:0] hdr [1:5];
    logic [7:0]  c;
    hdr[1] = 64'h001B_2133_4455_0010;
    hdr[2] = {32'h2030_4050, etype, 8'h45, 8'h00};
    hdr[3] = {16'h005C, 16'h1234, 16'h4000, 8'h40, proto};
    hdr[4] = {16'h145B ^ chk_xor, 32'h0A00_0001, 16'h0A00};
    hdr[5] = {16'h0002, 16'h3039, dport, 16'h0048};
    drive(64'h0000_0048_0001_0002, 8'hFF);
    for (int w = 1; w <= 5; w++) begin
      if (w == 3 && en_w3) enable = 1'b1;
      c = (w == eop_word || (w == 5 && npld == 0)) ? 8'h01 : 8'h00;
      drive(hdr[w], c);
      if (c != 8'h00) return;
    end
    for (int i = 0; i < npld; i++) begin
      if (i == stall_at) begin
        out_rdy = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          if (in_rdy === 1'b0) rdy_low++;
        end
        out_rdy = 1'b1;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      drive(pld_word(seq, i), (i == npld - 1) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    tests++; if (match_cnt !== 32'd0)      begin fails++; $display("FAIL reset_match_cnt: got %0d expected 0", match_cnt); end
    tests++; if (chksum_err_cnt !== 32'd0) begin fails++; $display("FAIL reset_chk_cnt: got %0d expected 0", chksum_err_cnt); end
    tests++; if (other_cnt !== 32'd0)      begin fails++; $display("FAIL reset_other_cnt: got %0d expected 0", other_cnt); end
    tests++; if ({pld_valid, pld_last, pkt_match, out_wr} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {pld_valid, pld_last, pkt_match, out_wr}); end
    tests++; if (out_data !== 64'd0 || pld_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %h/%h expected 0", out_data, pld_data); end
    reset = 1'b0;
    idle(1);
    mon_on = 1'b1;
  endtask

  task automatic test_match;
    q_pld.delete(); q_last.delete();
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 8, 0, -1, 1'b0, -1, 1);
    exp_match++;
    tests++; if (pkt_match !== 1'b1) begin fails++; $display("FAIL t1_pkt_match_pulse: got %b expected 1", pkt_match); end
    tests++; if (match_cnt !== 32'(exp_match)) begin fails++; $display("FAIL t1_match_cnt: got %0d expected %0d", match_cnt, exp_match); end
    idle(1);
    tests++; if (pkt_match !== 1'b0) begin fails++; $display("FAIL t1_pkt_match_width: got %b expected 0", pkt_match); end
    idle(1);
    tests++; if (q_pld.size() != 8) begin fails++; $display("FAIL t1_pld_count: got %0d expected 8", q_pld.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= q_pld.size() || q_pld[i] !== pld_word(1, i) || q_last[i] !== (i == 7)) begin
        fails++; $display("FAIL t1_pld_word[%0d]: got %h last=%b expected %h last=%b", i,
                          (i < q_pld.size()) ? q_pld[i] : 64'hx, (i < q_pld.size()) ? q_last[i] : 1'bx, pld_word(1, i), (i == 7));
      end
    end
  endtask

  task automatic test_chksum;
    int exp_n;
    q_pld.delete(); q_last.delete();
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0001, 8, 0, -1, 1'b0, -1, 2);
    idle(2);
`ifdef UDP_RX_CHKSUM_EN
    exp_chk++; exp_n = 0;
`else
    exp_match++; exp_n = 8;
`endif
    tests++; if (chksum_err_cnt !== 32'(exp_chk)) begin fails++; $display("FAIL t2_chk_cnt: got %0d expected %0d", chksum_err_cnt, exp_chk); end
    tests++; if (match_cnt !== 32'(exp_match))   begin fails++; $display("FAIL t2_match_cnt: got %0d expected %0d", match_cnt, exp_match); end
    tests++; if (q_pld.size() != exp_n)          begin fails++; $display("FAIL t2_pld_count: got %0d expected %0d", q_pld.size(), exp_n); end
  endtask

  task automatic test_other;
    int pulses0;
    q_pld.delete(); q_last.delete();
    pulses0 = match_pulses;
    send_pkt(16'h0806, 8'd17, 16'd5000, 16'h0000, 4, 0, -1, 1'b0, -1, 3);
    send_pkt(16'h0800, 8'd6,  16'd5000, 16'h0000, 4, 0, -1, 1'b0, -1, 3);
    send_pkt(16'h0800, 8'd17, 16'd5001, 16'h0000, 4, 0, -1, 1'b0, -1, 3);
    idle(2);
    exp_other += 3;
    tests++; if (other_cnt !== 32'(exp_other)) begin fails++; $display("FAIL t3_other_cnt: got %0d expected %0d", other_cnt, exp_other); end
    tests++; if (match_cnt !== 32'(exp_match)) begin fails++; $display("FAIL t3_match_cnt: got %0d expected %0d", match_cnt, exp_match); end
    tests++; if (q_pld.size() != 0)            begin fails++; $display("FAIL t3_pld_count: got %0d expected 0", q_pld.size()); end
    tests++; if (match_pulses != pulses0)      begin fails++; $display("FAIL t3_pkt_match: got %0d pulses expected %0d", match_pulses, pulses0); end
    tests++; if (dp_err != 0)                  begin fails++; $display("FAIL t3_datapath_delay: got %0d mismatching cycles expected 0", dp_err); end
  endtask

  task automatic test_enable;
    q_pld.delete(); q_last.delete();
    enable = 1'b0;
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 3, 0, -1, 1'b0, -1, 4);
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 3, 0, -1, 1'b1, -1, 4);
    idle(2);
    tests++; if ({match_cnt, chksum_err_cnt, other_cnt} !== {32'(exp_match), 32'(exp_chk), 32'(exp_other)}) begin
      fails++; $display("FAIL t4_disabled_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                        match_cnt, chksum_err_cnt, other_cnt, exp_match, exp_chk, exp_other);
    end
    tests++; if (q_pld.size() != 0) begin fails++; $display("FAIL t4_disabled_pld: got %0d expected 0", q_pld.size()); end
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 3, 0, -1, 1'b0, -1, 5);
    idle(2);
    exp_match++;
    tests++; if (match_cnt !== 32'(exp_match)) begin fails++; $display("FAIL t4_third_match: got %0d expected %0d", match_cnt, exp_match); end
    tests++; if (q_pld.size() != 3 || q_pld[0] !== pld_word(5, 0) || q_last[2] !== 1'b1) begin
      fails++; $display("FAIL t4_third_pld: got %0d beats expected 3 starting %h", q_pld.size(), pld_word(5, 0));
    end
  endtask

  task automatic test_short_and_reset;
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 8, 4, -1, 1'b0, -1, 6);
    idle(1);
    exp_other++;
    tests++; if (other_cnt !== 32'(exp_other)) begin fails++; $display("FAIL t5_short_other: got %0d expected %0d", other_cnt, exp_other); end
    tests++; if (match_cnt !== 32'(exp_match)) begin fails++; $display("FAIL t5_short_match: got %0d expected %0d", match_cnt, exp_match); end
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 8, 0, -1, 1'b0, 3, 7);
    exp_match = 0; exp_chk = 0; exp_other = 0;
    tests++; if ({match_cnt, chksum_err_cnt, other_cnt} !== 96'd0) begin
      fails++; $display("FAIL t5_reset_counts: got %0d/%0d/%0d expected 0/0/0", match_cnt, chksum_err_cnt, other_cnt);
    end
    tests++; if ({pld_valid, pkt_match} !== 2'b00) begin fails++; $display("FAIL t5_reset_flags: got %b expected 00", {pld_valid, pkt_match}); end
    q_pld.delete(); q_last.delete();
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 2, 0, -1, 1'b0, -1, 8);
    idle(2);
    exp_match++;
    tests++; if (match_cnt !== 32'(exp_match) || other_cnt !== 32'd0) begin
      fails++; $display("FAIL t5_after_reset: got match=%0d other=%0d expected %0d/0", match_cnt, other_cnt, exp_match);
    end
    tests++; if (q_pld.size() != 2 || q_pld[1] !== pld_word(8, 1) || q_last[1] !== 1'b1) begin
      fails++; $display("FAIL t5_after_reset_pld: got %0d beats expected 2 ending %h", q_pld.size(), pld_word(8, 1));
    end
  endtask

  task automatic test_stall;
    q_pld.delete(); q_last.delete();
    rdy_low = 0;
    send_pkt(16'h0800, 8'd17, 16'd5000, 16'h0000, 8, 0, 4, 1'b0, -1, 9);
    idle(2);
    exp_match++;
    tests++; if (rdy_low != 5) begin fails++; $display("FAIL t6_in_rdy_low: got %0d cycles expected 5", rdy_low); end
    tests++; if (match_cnt !== 32'(exp_match)) begin fails++; $display("FAIL t6_match_cnt: got %0d expected %0d", match_cnt, exp_match); end
    tests++; if (q_pld.size() != 8) begin fails++; $display("FAIL t6_pld_count: got %0d expected 8", q_pld.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= q_pld.size() || q_pld[i] !== pld_word(9, i) || q_last[i] !== (i == 7)) begin
        fails++; $display("FAIL t6_pld_order[%0d]: got %h expected %h", i,
                          (i < q_pld.size()) ? q_pld[i] : 64'hx, pld_word(9, i));
      end
    end
    tests++; if (dp_err != 0) begin fails++; $display("FAIL t6_datapath_delay: got %0d mismatching cycles expected 0", dp_err); end
  endtask

  initial begin
    #1;
    test_reset();
    test_match();
    test_chksum();
    test_other();
    test_enable();
    test_short_and_reset();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
